// File: rtl/btn_press_classifier_pkg.sv
// btn_press_classifier_pkg: shared helpers for the button classifier.
// Converts millisecond settings into clock ticks and counter widths.
package btn_press_classifier_pkg;

  function automatic int unsigned ms_to_ticks(
    input int unsigned freq,
    input int unsigned ms
  );
    return (freq / 1000) * ms;
  endfunction

  function automatic int cnt_width(input int unsigned n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// btn_sync_debounce: two-flop synchronizer, polarity normalization
// and stable-time debounce of a raw button input.
module btn_sync_debounce
  import btn_press_classifier_pkg::*;
#(
  parameter logic        BUTTON_INPUT_LEVEL = 1'b1,
  parameter int unsigned DB_TICKS           = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic usr_btn,
  output logic db_pressed,
  output logic raw_idle
);

  localparam int          W      = cnt_width(DB_TICKS);
  localparam logic [W-1:0] DB_MAX = W'(DB_TICKS);

  logic [1:0]   sync;
  logic [1:0]   primed;
  logic         raw_pressed;
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync   <= {2{~BUTTON_INPUT_LEVEL}};
      primed <= '0;
    end else begin
      sync   <= {sync[0], usr_btn};
      primed <= {primed[0], 1'b1};
    end
  end

  assign raw_pressed = (sync[1] == BUTTON_INPUT_LEVEL);
  // Released level is only trusted once real samples fill the synchronizer.
  assign raw_idle    = primed[1] & ~raw_pressed;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      db_pressed <= 1'b0;
      cnt        <= '0;
    end else if (raw_pressed == db_pressed) begin
      cnt <= '0;
    end else if (cnt == DB_MAX) begin
      db_pressed <= raw_pressed;
      cnt        <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_press_classifier.sv
// btn_press_classifier: debounced press level plus click and
// long-press pulses for a single mechanical button.
module btn_press_classifier
  import btn_press_classifier_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY          = 100000000,
  parameter logic        BUTTON_INPUT_LEVEL     = 1'b1,
  parameter logic        CLICK_OUTPUT_LEVEL     = 1'b1,
  parameter int unsigned CLICK_DEBOUNCE_MS      = 10,
  parameter logic        PRESS_OUTPUT_LEVEL     = 1'b1,
  parameter int unsigned LONG_PRESS_DURATION_MS = 1000
) (
  input  logic clk,
  input  logic resetn,
  input  logic usr_btn,
  output logic click,
  output logic press,
  output logic long_press
);

  localparam int unsigned DB_TICKS =
    ms_to_ticks(CLK_FREQUENCY, CLICK_DEBOUNCE_MS);
  localparam int unsigned LP_TICKS =
    ms_to_ticks(CLK_FREQUENCY, LONG_PRESS_DURATION_MS);
  localparam int           HW     = cnt_width(LP_TICKS);
  localparam logic [HW-1:0] LP_MAX = HW'(LP_TICKS);
  localparam logic         LP_EN  = (LP_TICKS != 0);

  logic          db_pressed;
  logic          raw_idle;
  logic          state_d;
  logic          fired;
  logic          armed;
  logic          fire;
  logic          click_q;
  logic          lp_q;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_nxt;

  btn_sync_debounce #(
    .BUTTON_INPUT_LEVEL(BUTTON_INPUT_LEVEL),
    .DB_TICKS          (DB_TICKS)
  ) u_db (
    .clk       (clk),
    .resetn    (resetn),
    .usr_btn   (usr_btn),
    .db_pressed(db_pressed),
    .raw_idle  (raw_idle)
  );

  always_comb begin
    hcnt_nxt = '0;
    if (db_pressed) begin
      hcnt_nxt = (hcnt == LP_MAX) ? hcnt : hcnt + 1'b1;
    end
  end

  assign fire = LP_EN & armed & db_pressed & ~fired &
                (hcnt_nxt == LP_MAX);

  // armed stays low after reset until a genuine release is observed,
  // so a hold that spans reset never classifies.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcnt    <= '0;
      fired   <= 1'b0;
      armed   <= 1'b0;
      state_d <= 1'b0;
      click_q <= 1'b0;
      lp_q    <= 1'b0;
    end else begin
      hcnt    <= hcnt_nxt;
      fired   <= db_pressed & (fired | fire);
      armed   <= armed | (raw_idle & ~db_pressed);
      state_d <= db_pressed;
      click_q <= state_d & ~db_pressed & ~fired & armed;
      lp_q    <= fire;
    end
  end

  assign press      = db_pressed ? PRESS_OUTPUT_LEVEL : ~PRESS_OUTPUT_LEVEL;
  assign click      = click_q ? CLICK_OUTPUT_LEVEL : ~CLICK_OUTPUT_LEVEL;
  assign long_press = lp_q ? PRESS_OUTPUT_LEVEL : ~PRESS_OUTPUT_LEVEL;

endmodule

// File: tb/tb_btn_press_classifier.sv
// tb_btn_press_classifier: three configurations driven by one logical
// button trace and checked against a trace-based reference model.
module tb_btn_press_classifier;

  localparam int unsigned FREQ = 10000;
  localparam int MAXK = 16384;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic p = 1'b0;
  logic p_n;
  logic [2:0] click_o;
  logic [2:0] press_o;
  logic [2:0] lp_o;

  assign p_n = ~p;

  always #5 clk = ~clk;

  btn_press_classifier #(
    .CLK_FREQUENCY(FREQ), .BUTTON_INPUT_LEVEL(1'b1),
    .CLICK_OUTPUT_LEVEL(1'b1), .CLICK_DEBOUNCE_MS(2),
    .PRESS_OUTPUT_LEVEL(1'b1), .LONG_PRESS_DURATION_MS(10)
  ) dut0 (
    .clk(clk), .resetn(resetn), .usr_btn(p),
    .click(click_o[0]), .press(press_o[0]), .long_press(lp_o[0])
  );

  btn_press_classifier #(
    .CLK_FREQUENCY(FREQ), .BUTTON_INPUT_LEVEL(1'b0),
    .CLICK_OUTPUT_LEVEL(1'b0), .CLICK_DEBOUNCE_MS(2),
    .PRESS_OUTPUT_LEVEL(1'b0), .LONG_PRESS_DURATION_MS(10)
  ) dut1 (
    .clk(clk), .resetn(resetn), .usr_btn(p_n),
    .click(click_o[1]), .press(press_o[1]), .long_press(lp_o[1])
  );

  btn_press_classifier #(
    .CLK_FREQUENCY(FREQ), .BUTTON_INPUT_LEVEL(1'b1),
    .CLICK_OUTPUT_LEVEL(1'b1), .CLICK_DEBOUNCE_MS(0),
    .PRESS_OUTPUT_LEVEL(1'b1), .LONG_PRESS_DURATION_MS(0)
  ) dut2 (
    .clk(clk), .resetn(resetn), .usr_btn(p),
    .click(click_o[2]), .press(press_o[2]), .long_press(lp_o[2])
  );

  int n_vec = 0;
  int n_fail = 0;
  int k = 0;
  int rise0 = -1;
  int n_click [3];
  int n_lp [3];
  int n_press [3];

  bit u_a [MAXK+1];
  bit st_a [3][MAXK+1];
  int hold_a [3][MAXK+1];
  bit arm_a [3][MAXK+1];

  function automatic int dbt(input int d);
    return (d == 2) ? 0 : 20;
  endfunction

  function automatic int lpt(input int d);
    return (d == 2) ? 0 : 100;
  endfunction

  function automatic logic act(input int d);
    return (d == 1) ? 1'b0 : 1'b1;
  endfunction

  function automatic bit uval(input int j);
    return (j < 1) ? 1'b0 : u_a[j];
  endfunction

  task automatic chk(input string tag, input int d,
                     input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] k=%0d observed=%b expected=%b",
             tag, d, k, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    u_a[0] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      st_a[d][0] = 1'b0;
      hold_a[d][0] = 0;
      arm_a[d][0] = 1'b0;
    end
  endtask

  // Debounced level flips once the synchronized input has disagreed with
  // it for DB+1 consecutive samples; events come from run lengths.
  task automatic model_step(input int d, output bit ep,
                            output bit ec, output bit el);
    int db;
    int lp;
    bit flip;
    db = dbt(d);
    lp = lpt(d);
    flip = 1'b1;
    for (int j = k - 2 - db; j <= k - 2; j++)
      if (uval(j) == st_a[d][k-1]) flip = 1'b0;
    st_a[d][k] = flip ? ~st_a[d][k-1] : st_a[d][k-1];
    hold_a[d][k] = st_a[d][k] ? hold_a[d][k-1] + 1 : 0;
    el = (lp > 0) && arm_a[d][k-1] && st_a[d][k-1] &&
         (hold_a[d][k-1] == lp);
    ec = (k >= 2) && st_a[d][k-2] && !st_a[d][k-1] && arm_a[d][k-1] &&
         ((lp == 0) || (hold_a[d][k-2] < lp));
    arm_a[d][k] = arm_a[d][k-1] ||
                  ((k >= 3) && !uval(k - 2) && !st_a[d][k-1]);
    ep = st_a[d][k];
  endtask

  task automatic mark();
    rise0 = -1;
    for (int d = 0; d < 3; d++) begin
      n_click[d] = 0;
      n_lp[d] = 0;
      n_press[d] = 0;
    end
  endtask

  task automatic cyc(input bit pv);
    bit ep;
    bit ec;
    bit el;
    p = pv;
    @(posedge clk);
    if (k >= MAXK) begin
      $display("FAIL model_depth k=%0d limit=%0d", k, MAXK);
      $fatal(1, "model depth exceeded");
    end
    k++;
    u_a[k] = pv;
    #1;
    for (int d = 0; d < 3; d++) begin
      model_step(d, ep, ec, el);
      chk("press", d, press_o[d], ep ? act(d) : ~act(d));
      chk("click", d, click_o[d], ec ? act(d) : ~act(d));
      chk("long_press", d, lp_o[d], el ? act(d) : ~act(d));
      if (click_o[d] === act(d)) n_click[d]++;
      if (lp_o[d] === act(d)) n_lp[d]++;
      if (press_o[d] === act(d)) n_press[d]++;
    end
    if (rise0 < 0 && press_o[0] === 1'b1) rise0 = k;
  endtask

  task automatic hold(input bit pv, input int n);
    repeat (n) cyc(pv);
  endtask

  task automatic chk_idle();
    for (int d = 0; d < 3; d++) begin
      chk("rst_press", d, press_o[d], ~act(d));
      chk("rst_click", d, click_o[d], ~act(d));
      chk("rst_long_press", d, lp_o[d], ~act(d));
    end
  endtask

  task automatic do_reset(input bit pv, input int n);
    p = pv;
    resetn = 1'b0;
    #1;
    chk_idle();
    repeat (n) begin
      @(posedge clk);
      #1;
      chk_idle();
    end
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    int kstep;
    int len;
    bit lvl;
    model_reset();
    mark();

    // Reset with the button held: asynchronous idle, then press after 23.
    #2;
    do_reset(1'b1, 3);
    mark();
    hold(1'b1, 150);
    chk_int("reset_press_latency", rise0, 23);
    chk_int("reset_no_long_press", n_lp[0], 0);
    hold(1'b0, 40);
    chk_int("reset_no_click", n_click[0], 0);

    // Bounce, then a stable hold.
    mark();
    repeat (4) begin
      hold(1'b1, 5);
      hold(1'b0, 3);
    end
    chk_int("bounce_no_press", n_press[0], 0);
    chk_int("bounce_no_click", n_click[0], 0);
    kstep = k;
    hold(1'b1, 60);
    chk_int("bounce_press_latency", rise0 - kstep, 23);
    chk_int("bounce_no_long_press", n_lp[0], 0);
    hold(1'b0, 40);

    // Short click.
    mark();
    hold(1'b1, 50);
    hold(1'b0, 40);
    chk_int("short_press_len", n_press[0], 50);
    chk_int("short_click_cnt", n_click[0], 1);
    chk_int("short_long_press_cnt", n_lp[0], 0);

    // Long press.
    mark();
    hold(1'b1, 300);
    hold(1'b0, 40);
    chk_int("long_press_len", n_press[0], 300);
    chk_int("long_long_press_cnt", n_lp[0], 1);
    chk_int("long_click_cnt", n_click[0], 0);

    // Inverted polarity at the long-press boundary.
    mark();
    hold(1'b1, 99);
    hold(1'b0, 40);
    chk_int("pol99_click_cnt", n_click[1], 1);
    chk_int("pol99_long_press_cnt", n_lp[1], 0);
    mark();
    hold(1'b1, 100);
    hold(1'b0, 40);
    chk_int("pol100_long_press_cnt", n_lp[1], 1);
    chk_int("pol100_click_cnt", n_click[1], 0);

    // Zero debounce, long-press disabled.
    mark();
    hold(1'b1, 1);
    hold(1'b0, 10);
    chk_int("zero_press_len", n_press[2], 1);
    chk_int("zero_click_cnt", n_click[2], 1);
    chk_int("zero_long_press_cnt", n_lp[2], 0);

    // Reset in the middle of a hold aborts classification.
    mark();
    hold(1'b1, 60);
    do_reset(1'b1, 2);
    hold(1'b1, 50);
    hold(1'b0, 40);
    chk_int("midrst_click_cnt", n_click[0], 0);
    chk_int("midrst_long_press_cnt", n_lp[0], 0);
    mark();
    hold(1'b1, 30);
    hold(1'b0, 40);
    chk_int("postrst_click_cnt", n_click[0], 1);

    // Random segments against the model.
    repeat (30) begin
      len = int'($urandom_range(1, 150));
      lvl = bit'($urandom_range(0, 1));
      hold(lvl, len);
    end
    hold(1'b0, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
